canxl_rx_fcrc_chk: RTL and testbench

Receive-side FCRC field sequencer and checker for the CAN XL receiver. It gates the 32-bit FCRC generator through `fcrc_enable`, freezes the computed CRC when the FCRC field begins, and captures the received FCRC bits while skipping fixed stuff bits (FSBs). It then compares the received and computed values, and flags FCRC mismatch and FSB polarity errors to the protocol controller.

---
 rtl/canxl_rx_fcrc_chk.sv | 153 +++++++++++++++
 tb/tb_canxl_rx_fcrc_chk.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/canxl_rx_fcrc_chk.sv
// CAN XL receive-side FCRC sequencer/checker.
// Gates the FCRC generator, freezes its result at the start of the FCRC field,
// captures the received FCRC while skipping fixed stuff bits, then compares.
module canxl_rx_fcrc_chk #(
    parameter int unsigned FCRC_W = 32
) (
    input  logic              clk,
    input  logic              g_rst,
    input  logic              initialize_i,
    input  logic              tx_success_i,
    input  logic              rx_success_i,
    input  logic [14:0]       rcvd_bt_cnt_i,
    input  logic              data_i,
    input  logic              fsb_i,
    input  logic              fcrc_start_i,
    input  logic [FCRC_W-1:0] fcrc_frm_i,
    output logic              fcrc_enable_o,
    output logic [FCRC_W-1:0] fcrc_rcvd_o,
    output logic [FCRC_W-1:0] fcrc_calc_o,
    output logic              fcrc_done_o,
    output logic              fcrc_err_o,
    output logic              fsb_err_o
);

    localparam logic [5:0] FullCnt = 6'(FCRC_W);

    typedef enum logic [1:0] {StIdle, StCalc, StRecv, StDone} state_e;

    state_e              state_q, state_d;
    logic [14:0]         prev_cnt_q;
    logic                last_bit_q;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [FCRC_W-1:0]   rcvd_q, rcvd_d;
    logic [FCRC_W-1:0]   calc_q, calc_d;
    logic                done_q, done_d;
    logic                fcrc_err_q, fcrc_err_d;
    logic                fsb_err_q, fsb_err_d;

    logic                new_bit;
    logic                clr;
    logic [FCRC_W-1:0]   shift_val;
    logic [5:0]          cnt_inc;

    // A change of the bit counter (wrap included) marks a new received bit.
    assign new_bit   = (rcvd_bt_cnt_i != prev_cnt_q);
    assign clr       = tx_success_i | rx_success_i | initialize_i;
    assign shift_val = {rcvd_q[FCRC_W-2:0], data_i};
    assign cnt_inc   = bit_cnt_q + 6'd1;

    // State register.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; success beats initialize beats normal sequencing.
    always_comb begin
        state_d = state_q;
        if (tx_success_i || rx_success_i) begin
            state_d = StIdle;
        end else if (initialize_i) begin
            state_d = StCalc;
        end else begin
            unique case (state_q)
                StCalc: if (new_bit && fcrc_start_i) state_d = StRecv;
                StRecv: if (new_bit && !fsb_i && cnt_inc == FullCnt) state_d = StDone;
                default: state_d = state_q;
            endcase
        end
    end

    // Generator enable: drops combinationally on the first FCRC bit so it is excluded.
    always_comb begin
        fcrc_enable_o = (state_q == StCalc) && !(new_bit && fcrc_start_i);
    end

    // Datapath next-state: snapshot, shift-in, completion and error flags.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rcvd_d     = rcvd_q;
        calc_d     = calc_q;
        done_d     = 1'b0;
        fcrc_err_d = fcrc_err_q;
        fsb_err_d  = fsb_err_q;
        if (clr) begin
            bit_cnt_d  = '0;
            rcvd_d     = '0;
            calc_d     = '0;
            fcrc_err_d = 1'b0;
            fsb_err_d  = 1'b0;
        end else if (new_bit) begin
            unique case (state_q)
                StCalc: begin
                    if (fcrc_start_i) begin
                        calc_d = fcrc_frm_i;
                        if (!fsb_i) begin
                            rcvd_d    = shift_val;
                            bit_cnt_d = 6'd1;
                        end else begin
                            bit_cnt_d = 6'd0;
                        end
                    end
                end
                StRecv: begin
                    if (!fsb_i) begin
                        rcvd_d    = shift_val;
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == FullCnt) begin
                            done_d = 1'b1;
                            if (shift_val != calc_q) fcrc_err_d = 1'b1;
                        end
                    end else if (data_i == last_bit_q) begin
                        fsb_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; prev_cnt and last_bit track the line in every state.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            prev_cnt_q <= '0;
            last_bit_q <= 1'b0;
            bit_cnt_q  <= '0;
            rcvd_q     <= '0;
            calc_q     <= '0;
            done_q     <= 1'b0;
            fcrc_err_q <= 1'b0;
            fsb_err_q  <= 1'b0;
        end else begin
            prev_cnt_q <= rcvd_bt_cnt_i;
            if (new_bit) last_bit_q <= data_i;
            bit_cnt_q  <= bit_cnt_d;
            rcvd_q     <= rcvd_d;
            calc_q     <= calc_d;
            done_q     <= done_d;
            fcrc_err_q <= fcrc_err_d;
            fsb_err_q  <= fsb_err_d;
        end
    end

    assign fcrc_rcvd_o = rcvd_q;
    assign fcrc_calc_o = calc_q;
    assign fcrc_done_o = done_q;
    assign fcrc_err_o  = fcrc_err_q;
    assign fsb_err_o   = fsb_err_q;

endmodule

// File: tb/tb_canxl_rx_fcrc_chk.sv
// Directed bench for canxl_rx_fcrc_chk: match, FSB handling, mismatch, abort,
// counter wrap, async reset and success clear.
module tb_canxl_rx_fcrc_chk;

    logic        clk = 1'b0;
    logic        g_rst;
    logic        initialize, tx_success, rx_success;
    logic [14:0] rcvd_bt_cnt;
    logic        data, fsb, fcrc_start;
    logic [31:0] fcrc_frm;
    logic        fcrc_enable, fcrc_done, fcrc_err, fsb_err;
    logic [31:0] fcrc_rcvd, fcrc_calc;

    int total = 0;
    int bad   = 0;

    canxl_rx_fcrc_chk #(.FCRC_W(32)) dut (
        .clk          (clk),
        .g_rst        (g_rst),
        .initialize_i (initialize),
        .tx_success_i (tx_success),
        .rx_success_i (rx_success),
        .rcvd_bt_cnt_i(rcvd_bt_cnt),
        .data_i       (data),
        .fsb_i        (fsb),
        .fcrc_start_i (fcrc_start),
        .fcrc_frm_i   (fcrc_frm),
        .fcrc_enable_o(fcrc_enable),
        .fcrc_rcvd_o  (fcrc_rcvd),
        .fcrc_calc_o  (fcrc_calc),
        .fcrc_done_o  (fcrc_done),
        .fcrc_err_o   (fcrc_err),
        .fsb_err_o    (fsb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one new bit at a negedge; optionally check the enable mid-cycle.
    task automatic send_bit(input logic d, input logic f, input logic s,
                            input bit chk_en, input logic exp_en);
        rcvd_bt_cnt = rcvd_bt_cnt + 15'd1;
        data        = d;
        fsb         = f;
        fcrc_start  = s;
        if (chk_en) begin
            #1;
            check("enable_same_cycle", {31'd0, fcrc_enable}, {31'd0, exp_en});
        end
        @(negedge clk);
        fsb        = 1'b0;
        fcrc_start = 1'b0;
    endtask

    task automatic pulse_init();
        initialize = 1'b1;
        @(negedge clk);
        initialize = 1'b0;
    endtask

    task automatic calc_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'(i % 3 == 0), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send the first nbits of v MSB first; optional FSBs after bits 10/20/30,
    // the one after bit 30 repeating the preceding bit.
    task automatic send_field(input logic [31:0] v, input int nbits, input bit with_fsb);
        logic b;
        for (int k = 1; k <= nbits; k++) begin
            b = v[32-k];
            send_bit(b, 1'b0, k == 1, k == 1, 1'b0);
            if (with_fsb && (k == 10 || k == 20 || k == 30)) begin
                send_bit((k == 30) ? b : ~b, 1'b1, 1'b0, 1'b0, 1'b0);
                check("fsb_err_after_fsb", {31'd0, fsb_err}, {31'd0, (k == 30)});
            end
        end
    endtask

    initial begin
        g_rst = 1'b1; initialize = 1'b0; tx_success = 1'b0; rx_success = 1'b0;
        rcvd_bt_cnt = 15'd0; data = 1'b0; fsb = 1'b0; fcrc_start = 1'b0;
        fcrc_frm = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_enable", {31'd0, fcrc_enable}, 32'd0);
        check("rst_rcvd", fcrc_rcvd, 32'd0);
        check("rst_calc", fcrc_calc, 32'd0);
        check("rst_flags", {29'd0, fcrc_done, fcrc_err, fsb_err}, 32'd0);
        g_rst = 1'b0;
        @(negedge clk);

        // Match
        fcrc_frm = 32'hDEADBEEF;
        pulse_init();
        check("calc_enable", {31'd0, fcrc_enable}, 32'd1);
        calc_bits(20);
        check("calc_enable_after_bits", {31'd0, fcrc_enable}, 32'd1);
        fcrc_frm = 32'hDEADBEEF;
        send_field(32'hDEADBEEF, 32, 1'b0);
        check("match_done", {31'd0, fcrc_done}, 32'd1);
        check("match_err", {31'd0, fcrc_err}, 32'd0);
        check("match_rcvd", fcrc_rcvd, 32'hDEADBEEF);
        check("match_calc", fcrc_calc, 32'hDEADBEEF);
        check("match_enable_recv", {31'd0, fcrc_enable}, 32'd0);
        @(negedge clk);
        check("match_done_one_cycle", {31'd0, fcrc_done}, 32'd0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_ignores_bits", fcrc_rcvd, 32'hDEADBEEF);

        // FSB skip and error
        pulse_init();
        check("init_clears_rcvd", fcrc_rcvd, 32'd0);
        calc_bits(20);
        send_field(32'hDEADBEEF, 32, 1'b1);
        check("fsb_done", {31'd0, fcrc_done}, 32'd1);
        check("fsb_rcvd", fcrc_rcvd, 32'hDEADBEEF);
        check("fsb_fcrc_err", {31'd0, fcrc_err}, 32'd0);
        check("fsb_err_sticky", {31'd0, fsb_err}, 32'd1);

        // Mismatch
        fcrc_frm = 32'h12345678;
        pulse_init();
        check("init_clears_fsb_err", {31'd0, fsb_err}, 32'd0);
        calc_bits(5);
        send_field(32'h12345679, 32, 1'b0);
        check("mis_done", {31'd0, fcrc_done}, 32'd1);
        check("mis_err", {31'd0, fcrc_err}, 32'd1);
        check("mis_calc", fcrc_calc, 32'h12345678);
        check("mis_rcvd", fcrc_rcvd, 32'h12345679);

        // Success clear, then fcrc_start without initialize is ignored
        rx_success = 1'b1;
        @(negedge clk);
        rx_success = 1'b0;
        check("succ_err_clear", {31'd0, fcrc_err}, 32'd0);
        check("succ_idle_enable", {31'd0, fcrc_enable}, 32'd0);
        check("succ_calc_clear", fcrc_calc, 32'd0);
        send_field(32'hFFFFFFFF, 32, 1'b0);
        check("idle_start_rcvd", fcrc_rcvd, 32'd0);
        check("idle_start_done", {31'd0, fcrc_done}, 32'd0);

        // Abort after 16 FCRC bits
        fcrc_frm = 32'hAAAA5555;
        pulse_init();
        calc_bits(5);
        send_field(32'hDEADBEEF, 16, 1'b0);
        check("abort_partial", fcrc_rcvd, 32'h0000DEAD);
        pulse_init();
        check("abort_done", {31'd0, fcrc_done}, 32'd0);
        check("abort_rcvd", fcrc_rcvd, 32'd0);
        check("abort_enable", {31'd0, fcrc_enable}, 32'd1);
        @(negedge clk);
        check("abort_no_late_done", {31'd0, fcrc_done}, 32'd0);

        // Counter wrap: 0x7FFE (start) -> 0x7FFF -> 0x0000
        rcvd_bt_cnt = 15'h7FFC;
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_cnt", {17'd0, rcvd_bt_cnt}, 32'd0);
        check("wrap_rcvd", fcrc_rcvd, 32'h5);
        check("wrap_calc", fcrc_calc, 32'hAAAA5555);

        // Asynchronous reset mid-RECV
        g_rst = 1'b1;
        #1;
        check("arst_rcvd", fcrc_rcvd, 32'd0);
        check("arst_calc", fcrc_calc, 32'd0);
        check("arst_flags", {28'd0, fcrc_enable, fcrc_done, fcrc_err, fsb_err}, 32'd0);
        @(negedge clk);
        g_rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, fcrc_enable}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
